// File: rtl/pll_lock_supervisor_if.sv
// Signal bundle between the PLL lock supervisor and its PLL / system neighbours.
// The slave side is the supervisor; the master side drives lock and retry requests.
interface pll_lock_supervisor_if;
    logic       pll_lock;
    logic       retry_req;
    logic       pll_rst;
    logic       rst_out;
    logic       locked_ok;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] lock_lost_cnt;

    modport master (
        output pll_lock, retry_req,
        input  pll_rst, rst_out, locked_ok, fail, retry_cnt, lock_lost_cnt
    );

    modport slave (
        input  pll_lock, retry_req,
        output pll_rst, rst_out, locked_ok, fail, retry_cnt, lock_lost_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, qualifies a synchronized lock for a
// stable window, then releases the system reset; retries on timeout, parks in FAIL.
//   state     | meaning
//   RESET_PLL | pll_rst held high for RST_CYCLES
//   WAIT_LOCK | waiting for lock, bounded by LOCK_TIMEOUT
//   STABLE    | lock must stay high for LOCK_STABLE cycles
//   RUN       | system out of reset, watching for lock loss
//   FAIL      | retries exhausted, waiting for retry_req
module pll_lock_supervisor #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 7
) (
    input  logic                 clkin1,
    input  logic                 sys_rst,
    pll_lock_supervisor_if.slave bus
);
    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    localparam logic [CW-1:0] RST_TC    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_TC = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_TC = CW'(LOCK_STABLE - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_lock_meta;
    logic          r_lock_s;
    logic [3:0]    r_retry_cnt;
    logic [7:0]    r_lost_cnt;
    logic          r_pll_rst;
    logic          r_rst_out;
    logic          r_locked_ok;
    logic          r_fail;
    logic          w_retry_inc;
    logic          w_retry_clr;
    logic          w_lost_inc;
    logic          w_counting;

    // Lock loss is tested before any terminal count, so it wins a same-cycle tie.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_retry_clr = 1'b0;
        w_lost_inc  = 1'b0;
        case (r_state)
            S_RESET_PLL: begin
                if (r_cnt == RST_TC) w_state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nxt = S_STABLE;
                end else if (r_cnt == TIMEOUT_TC) begin
                    if (r_retry_cnt == RETRY_MAX) begin
                        w_state_nxt = S_FAIL;
                    end else begin
                        w_retry_inc = 1'b1;
                        w_state_nxt = S_RESET_PLL;
                    end
                end
            end
            S_STABLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_cnt == STABLE_TC) begin
                    w_retry_clr = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!r_lock_s) begin
                    w_lost_inc  = 1'b1;
                    w_state_nxt = S_RESET_PLL;
                end
            end
            S_FAIL: begin
                if (bus.retry_req) begin
                    w_retry_clr = 1'b1;
                    w_state_nxt = S_RESET_PLL;
                end
            end
            default: w_state_nxt = S_RESET_PLL;
        endcase
    end

    assign w_counting = (r_state == S_RESET_PLL) || (r_state == S_WAIT_LOCK) ||
                        (r_state == S_STABLE);

    always_ff @(posedge clkin1) begin
        if (sys_rst) begin
            r_state     <= S_RESET_PLL;
            r_cnt       <= '0;
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_retry_cnt <= '0;
            r_lost_cnt  <= '0;
            r_pll_rst   <= 1'b1;
            r_rst_out   <= 1'b1;
            r_locked_ok <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_lock_meta <= bus.pll_lock;
            r_lock_s    <= r_lock_meta;
            r_state     <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_counting) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_retry_clr) begin
                r_retry_cnt <= '0;
            end else if (w_retry_inc) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
            end
            if (w_lost_inc && (r_lost_cnt != 8'hFF)) begin
                r_lost_cnt <= r_lost_cnt + 1'b1;
            end
            // Outputs are registered from the next state so they line up with r_state.
            r_pll_rst   <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAIL);
            r_rst_out   <= (w_state_nxt != S_RUN);
            r_locked_ok <= (w_state_nxt == S_RUN);
            r_fail      <= (w_state_nxt == S_FAIL);
        end
    end

    assign bus.pll_rst       = r_pll_rst;
    assign bus.rst_out       = r_rst_out;
    assign bus.locked_ok     = r_locked_ok;
    assign bus.fail          = r_fail;
    assign bus.retry_cnt     = r_retry_cnt;
    assign bus.lock_lost_cnt = r_lost_cnt;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: a cycle model predicts every output vector, a
// monitor thread compares the DUT against the predictions queued by the stimulus.
module tb_pll_lock_supervisor;
    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRY    = 2;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;
    localparam int P_FAIL = 4;

    typedef struct packed {
        logic       pll_rst;
        logic       rst_out;
        logic       locked_ok;
        logic       fail;
        logic [3:0] retry;
        logic [7:0] lost;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst;

    pll_lock_supervisor_if bus_if ();

    pll_lock_supervisor #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clkin1 (clk),
        .sys_rst(sys_rst),
        .bus    (bus_if)
    );

    always #10 clk = ~clk;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_a;
    int   n_checks = 0;
    int   n_errors = 0;
    int   mon_idx  = 0;

    // Reference model: phase plus the edge at which it was entered; lock seen by
    // the control is the input applied two edges earlier (zeroed by reset).
    int cyc     = 0;
    int ph      = P_RST;
    int t_entry = 0;
    int retries = 0;
    int losses  = 0;
    bit dl0     = 1'b0;
    bit dl1     = 1'b0;

    task automatic enter(input int p);
        ph      = p;
        t_entry = cyc;
    endtask

    task automatic model_edge(input bit rst, input bit lk, input bit rq);
        bit   ls;
        int   el;
        exp_t e;
        ls = dl1;
        el = cyc - t_entry - 1;
        if (rst) begin
            dl0 = 1'b0; dl1 = 1'b0;
            ph = P_RST; t_entry = cyc;
            retries = 0; losses = 0;
        end else begin
            dl1 = dl0;
            dl0 = lk;
            case (ph)
                P_RST:  if (el == RST_CYCLES - 1) enter(P_WAIT);
                P_WAIT: begin
                    if (ls) enter(P_STAB);
                    else if (el == LOCK_TIMEOUT - 1) begin
                        if (retries == MAX_RETRY) enter(P_FAIL);
                        else begin retries++; enter(P_RST); end
                    end
                end
                P_STAB: begin
                    if (!ls) enter(P_WAIT);
                    else if (el == LOCK_STABLE - 1) begin retries = 0; enter(P_RUN); end
                end
                P_RUN:  if (!ls) begin if (losses < 255) losses++; enter(P_RST); end
                P_FAIL: if (rq) begin retries = 0; enter(P_RST); end
                default: ;
            endcase
        end
        cyc++;
        e.pll_rst   = (ph == P_RST) || (ph == P_FAIL);
        e.rst_out   = (ph != P_RUN);
        e.locked_ok = (ph == P_RUN);
        e.fail      = (ph == P_FAIL);
        e.retry     = 4'(retries);
        e.lost      = 8'(losses);
        exp_q.push_back(e);
    endtask

    task automatic tick(input bit rst, input bit lk, input bit rq);
        @(negedge clk);
        sys_rst          = rst;
        bus_if.pll_lock  = lk;
        bus_if.retry_req = rq;
        model_edge(rst, lk, rq);
    endtask

    task automatic run_until(input int p, input bit lk, input int budget);
        int n;
        n = 0;
        while (ph != p && n < budget) begin
            tick(1'b0, lk, 1'b0);
            n++;
        end
        if (ph != p) begin
            n_errors++;
            $display("FAIL wait_phase: phase %0d reached, phase %0d required within %0d cycles",
                     ph, p, budget);
        end
    endtask

    initial begin
        sys_rst          = 1'b1;
        bus_if.pll_lock  = 1'b0;
        bus_if.retry_req = 1'b0;
        fork
            begin : monitor
                forever begin
                    @(posedge clk);
                    #1;
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        mon_a = {bus_if.pll_rst, bus_if.rst_out, bus_if.locked_ok, bus_if.fail,
                                 bus_if.retry_cnt, bus_if.lock_lost_cnt};
                        n_checks++;
                        if (mon_a !== mon_e) begin
                            n_errors++;
                            if (n_errors <= 25)
                                $display("FAIL outputs cyc=%0d: got pll_rst=%b rst_out=%b locked_ok=%b fail=%b retry_cnt=%0d lost=%0d, required pll_rst=%b rst_out=%b locked_ok=%b fail=%b retry_cnt=%0d lost=%0d",
                                         mon_idx, mon_a.pll_rst, mon_a.rst_out, mon_a.locked_ok,
                                         mon_a.fail, mon_a.retry, mon_a.lost, mon_e.pll_rst,
                                         mon_e.rst_out, mon_e.locked_ok, mon_e.fail, mon_e.retry,
                                         mon_e.lost);
                        end
                        mon_idx++;
                    end
                end
            end
            begin : stimulus
                // reset with random inputs, then nominal lock from cycle 6
                repeat (3) tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                repeat (6) tick(1'b0, 1'b0, 1'b0);
                run_until(P_RUN, 1'b1, 40);
                repeat (5) tick(1'b0, 1'b1, 1'($urandom_range(0, 1)));

                // loss in RUN, then a 3-cycle glitch in STABLE
                tick(1'b0, 1'b0, 1'b0);
                run_until(P_STAB, 1'b1, 40);
                while (ph == P_STAB && (cyc - t_entry - 1) < 3) tick(1'b0, 1'b1, 1'b0);
                repeat (3) tick(1'b0, 1'b0, 1'b0);
                run_until(P_RUN, 1'b1, 60);

                // lock drop landing exactly on the stable terminal count
                tick(1'b0, 1'b0, 1'b0);
                run_until(P_STAB, 1'b1, 40);
                while (ph == P_STAB && (cyc + 1 - t_entry) < LOCK_STABLE - 1)
                    tick(1'b0, 1'b1, 1'b0);
                tick(1'b0, 1'b0, 1'b0);
                run_until(P_RUN, 1'b1, 60);

                // no lock: retry pulses until FAIL, retry_req only honoured there
                for (int k = 0; k < 200 && ph != P_FAIL; k++)
                    tick(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                repeat (8) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                tick(1'b0, 1'b0, 1'b1);
                repeat (3) tick(1'b0, 1'b0, 1'b0);

                // sys_rst in the middle of WAIT_LOCK
                run_until(P_WAIT, 1'b0, 20);
                repeat (5) tick(1'b0, 1'b0, 1'b0);
                tick(1'b1, 1'b1, 1'b0);
                repeat (3) tick(1'b0, 1'b1, 1'b0);

                // random segments of lock, retry requests and occasional resets
                for (int s = 0; s < 80; s++) begin
                    int len;
                    bit lk;
                    len = $urandom_range(1, 30);
                    lk  = ($urandom_range(0, 3) != 0);
                    for (int k = 0; k < len; k++)
                        tick(($urandom_range(0, 199) == 0), lk, ($urandom_range(0, 15) == 0));
                end

                // saturate the lock-loss counter
                tick(1'b1, 1'b1, 1'b0);
                for (int k = 0; k < 260; k++) begin
                    run_until(P_RUN, 1'b1, 40);
                    tick(1'b0, 1'b0, 1'b0);
                end
                run_until(P_RUN, 1'b1, 40);
                repeat (3) tick(1'b0, 1'b1, 1'b0);
            end
        join_any

        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d predictions left, 0 required", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 16: cycles pll_rst is held high per PLL reset pulse (≥2).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 50000: cycles allowed for lock after pll_rst release (≥2; 1 ms at 50 MHz).
REQ-003 SHALL have parameter LOCK_STABLE, default 1024: consecutive synchronized lock-high cycles required before system reset release (≥2).
REQ-004 SHALL have parameter MAX_RETRY, default 7: timeouts tolerated before FAIL (0..15).
REQ-005 SHALL have port clkin1, input, 1: single clock, PLL reference clock (50 MHz).
REQ-006 SHALL have port sys_rst, input, 1: reset; synchronous, active-high.
REQ-007 SHALL have port pll_lock, input, 1: PLL lock indication, asynchronous to clkin1.
REQ-008 SHALL have port retry_req, input, 1: single-cycle request to leave FAIL.
REQ-009 SHALL have port pll_rst, output, 1: reset to PLL, active-high.
REQ-010 SHALL have port rst_out, output, 1: downstream system reset, active-high.
REQ-011 SHALL have port locked_ok, output, 1: high only in RUN.
REQ-012 SHALL have port fail, output, 1: high only in FAIL.
REQ-013 SHALL have port retry_cnt, output, 4: timeouts since last RUN or FAIL exit.
REQ-014 SHALL have port lock_lost_cnt, output, 8: lock losses seen in RUN, saturating.

Function
REQ-015 SHALL synchronize pll_lock through two clkin1 flops (lock_s); lock_s SHALL be the only lock source used by the FSM; latency 2 cycles.
REQ-016 SHALL implement FSM states RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL, with one shared cycle counter whose width is at least clog2 of the largest of RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE.
REQ-017 SHALL clear the counter on every state entry.
REQ-018 RESET_PLL: SHALL advance to WAIT_LOCK when counter == RST_CYCLES-1, giving exactly RST_CYCLES cycles in the state.
REQ-019 WAIT_LOCK: if lock_s=1, SHALL go to STABLE.
REQ-020 WAIT_LOCK: else if counter == LOCK_TIMEOUT-1 and retry_cnt == MAX_RETRY, SHALL go to FAIL.
REQ-021 WAIT_LOCK: else if counter == LOCK_TIMEOUT-1, SHALL increment retry_cnt and go to RESET_PLL.
REQ-022 STABLE: if lock_s=0, SHALL go to WAIT_LOCK with retry_cnt unchanged.
REQ-023 STABLE: else if counter == LOCK_STABLE-1, SHALL go to RUN and clear retry_cnt.
REQ-024 RUN: if lock_s=0, SHALL increment lock_lost_cnt (hold at 255) and go to RESET_PLL.
REQ-025 FAIL: SHALL stay until retry_req=1, then clear retry_cnt and go to RESET_PLL.
REQ-026 Outputs SHALL be Moore, registered, decoded from the state register. pll_rst=1 in RESET_PLL and FAIL. rst_out=0 only in RUN. locked_ok=1 only in RUN. fail=1 only in FAIL.
REQ-027 retry_req outside FAIL SHALL be ignored.
REQ-028 A lock_s falling edge on the same cycle as a counter terminal value SHALL take the lock-loss path (lock_s has priority over the counter).

Reset
REQ-029 sys_rst=1 SHALL override all inputs, including mid-sequence.
REQ-030 During sys_rst=1 and on the cycle after it falls: state=RESET_PLL, counter=0, sync flops=0, retry_cnt=0, lock_lost_cnt=0, pll_rst=1, rst_out=1, locked_ok=0, fail=0.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2)
REQ-031 Nominal: release sys_rst at cycle 0, pll_lock=1 from cycle 6 -> pll_rst high cycles 0-3; rst_out falls and locked_ok rises 2+8 (±1) cycles after lock edge; retry_cnt=0.
REQ-032 No lock: pll_lock=0 forever -> three 4-cycle pll_rst pulses separated by 20 cycles, then fail=1, pll_rst=1, retry_cnt=2, rst_out=1 held.
REQ-033 Glitch: pll_lock low 3 cycles during STABLE at counter 5 -> back to WAIT_LOCK, stable count restarts from 0, rst_out never drops.
REQ-034 Loss in RUN: drop pll_lock -> within 3 cycles rst_out=1, locked_ok=0, lock_lost_cnt=1, new 4-cycle pll_rst pulse; relock returns to RUN.
REQ-035 Recovery/reset: retry_req pulse in FAIL -> retry_cnt=0, pll_rst pulse restarts; sys_rst asserted mid-WAIT_LOCK -> all outputs at reset values next cycle; 256 RUN losses -> lock_lost_cnt=255.
